// File: rtl/ysyx_210544_clint_bridge.sv
// rtl/ysyx_210544_clint_bridge.sv - LSU-to-CLINT register bridge with RMW stores and timer irq
module ysyx_210544_clint_bridge #(
  parameter logic [63:0] MTIME_ADDR    = 64'h0200_BFF8,
  parameter logic [63:0] MTIMECMP_ADDR = 64'h0200_4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [63:0] i_req_addr,
  input  logic        i_req_wen,
  input  logic [1:0]  i_req_size,
  input  logic [63:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [63:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [63:0] o_clint_addr,
  output logic        o_clint_ren,
  input  logic [63:0] i_clint_rdata,
  output logic        o_clint_wen,
  output logic [63:0] o_clint_wdata,
  input  logic        i_clint_mtime_overflow,
  output logic        o_timer_irq
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [63:0] base_q;
  logic [2:0]  off_q;
  logic        wen_q;
  logic [1:0]  size_q;
  logic [63:0] wdata_q;
  logic [63:0] old_q;
  logic        err_q;
  logic        irq_q;

  logic [63:0] req_base;
  logic        req_bad_addr;
  logic        req_misalign;
  logic        req_err;
  logic        req_fire;
  logic [63:0] lane_mask;
  logic [5:0]  lane_shift;
  logic [63:0] merged_wdata;

  assign req_base     = {i_req_addr[63:3], 3'b000};
  assign req_bad_addr = (req_base != MTIME_ADDR) && (req_base != MTIMECMP_ADDR);
  assign req_err      = req_bad_addr || req_misalign;
  assign req_fire     = i_req_valid && (state_q == S_IDLE);

  // Natural alignment: the offset must be a multiple of the access size.
  always_comb begin
    req_misalign = 1'b0;
    case (i_req_size)
      2'd0:    req_misalign = 1'b0;
      2'd1:    req_misalign = i_req_addr[0];
      2'd2:    req_misalign = |i_req_addr[1:0];
      default: req_misalign = |i_req_addr[2:0];
    endcase
  end

  // Byte-lane mask of the latched access size, right-aligned.
  always_comb begin
    lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (size_q)
      2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
      2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  assign lane_shift = {off_q, 3'b000};

  // Full doubleword stores bypass the merge; partial ones splice into the old value.
  assign merged_wdata = (size_q == 2'd3) ? wdata_q
                      : ((old_q & ~(lane_mask << lane_shift)) |
                         ((wdata_q & lane_mask) << lane_shift));

  // Next-state and strobe decode; strobes and address are only live in READ/WRITE.
  always_comb begin
    state_d       = state_q;
    o_req_ready   = 1'b0;
    o_resp_valid  = 1'b0;
    o_clint_ren   = 1'b0;
    o_clint_wen   = 1'b0;
    o_clint_addr  = 64'd0;
    o_clint_wdata = 64'd0;
    case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (req_err)                          state_d = S_RESP;
          else if (i_req_wen && i_req_size == 2'd3) state_d = S_WRITE;
          else                                  state_d = S_READ;
        end
      end
      S_READ: begin
        o_clint_ren  = 1'b1;
        o_clint_addr = base_q;
        state_d      = wen_q ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        o_clint_wen   = 1'b1;
        o_clint_addr  = base_q;
        o_clint_wdata = merged_wdata;
        state_d       = S_RESP;
      end
      default: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) state_d = S_IDLE;
      end
    endcase
  end

  // Response payload is derived from held state, so it stays stable while stalled.
  assign o_resp_err   = (state_q == S_RESP) && err_q;
  assign o_resp_rdata = ((state_q == S_RESP) && !err_q && !wen_q)
                      ? ((old_q >> lane_shift) & lane_mask) : 64'd0;
  assign o_timer_irq  = irq_q;

  // State register plus request latch; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= 64'd0;
      off_q   <= 3'd0;
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      wdata_q <= 64'd0;
      old_q   <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        base_q  <= req_base;
        off_q   <= i_req_addr[2:0];
        wen_q   <= i_req_wen;
        size_q  <= i_req_size;
        wdata_q <= i_req_wdata;
        err_q   <= req_err;
        old_q   <= 64'd0;
      end
      if (state_q == S_READ) old_q <= i_clint_rdata;
    end
  end

  // Machine timer interrupt is the overflow level delayed by one cycle.
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= i_clint_mtime_overflow;
  end

endmodule

// File: tb/tb_ysyx_210544_clint_bridge.sv
// tb/tb_ysyx_210544_clint_bridge.sv - self-checking bench for the CLINT bridge
module tb_ysyx_210544_clint_bridge;

  localparam logic [63:0] MT  = 64'h0200_BFF8;
  localparam logic [63:0] CMP = 64'h0200_4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = 64'd0;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] clint_addr;
  logic        clint_ren;
  logic [63:0] clint_rdata;
  logic        clint_wen;
  logic [63:0] clint_wdata;
  logic        ovf;
  logic        timer_irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_210544_clint_bridge dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_wen(req_wen), .i_req_size(req_size), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_clint_addr(clint_addr), .o_clint_ren(clint_ren), .i_clint_rdata(clint_rdata),
    .o_clint_wen(clint_wen), .o_clint_wdata(clint_wdata),
    .i_clint_mtime_overflow(ovf), .o_timer_irq(timer_irq)
  );

  // CLINT model: free-running mtime, writable mtimecmp, mtime writes ignored.
  logic [63:0] mtime = 64'd0;
  logic [63:0] mtimecmp = 64'd5000;
  always @(posedge clk) begin
    mtime <= mtime + 64'd1;
    if (clint_wen && clint_addr == CMP) mtimecmp <= clint_wdata;
  end
  assign clint_rdata = (clint_addr == CMP) ? mtimecmp : (clint_addr == MT) ? mtime : 64'd0;
  assign ovf = mtime > mtimecmp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Interrupt delay monitor: irq this cycle must equal overflow of the previous cycle.
  logic irq_chk = 1'b0;
  logic prev_ovf = 1'b0;
  always @(negedge clk) begin
    if (irq_chk) chk("irq_delay", {63'd0, timer_irq}, {63'd0, prev_ovf});
    prev_ovf = ovf;
  end

  task automatic do_req(input logic [63:0] a, input logic w, input logic [1:0] s,
                        input logic [63:0] d, input int stall,
                        output logic [63:0] rd, output logic er, output int lat,
                        output int nren, output int nwen, output logic [63:0] wd,
                        output logic addr_ok);
    logic timed_out;
    rd = 64'd0; er = 1'b0; lat = 0; nren = 0; nwen = 0; wd = 64'd0; addr_ok = 1'b1;
    timed_out = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_wen = w; req_size = s; req_wdata = d;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      if (clint_ren) begin
        nren++;
        if (clint_addr != {a[63:3], 3'b000}) addr_ok = 1'b0;
      end
      if (clint_wen) begin
        nwen++;
        wd = clint_wdata;
        if (clint_addr != {a[63:3], 3'b000}) addr_ok = 1'b0;
      end
      if (resp_valid) break;
      if (lat >= 12) begin
        timed_out = 1'b1;
        break;
      end
    end
    if (timed_out) begin
      chk("resp_timeout", 64'd0, 64'd1);
    end else begin
      rd = resp_rdata;
      er = resp_err;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk("stall_valid", {63'd0, resp_valid}, 64'd1);
        chk("stall_rdata", resp_rdata, rd);
        chk("stall_err", {63'd0, resp_err}, {63'd0, er});
        chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
        if (clint_ren || clint_wen) nren = nren + 100;
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    logic        w;
    logic [1:0]  s;
    logic [63:0] d;
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          nren;
    int          nwen;
    logic        chkwd;
    logic [63:0] wd;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [63:0] rd, wd, sh, exp_rd, a, d;
    logic er, ok, w, bad, mis, err_e, to_cmp;
    logic [1:0] s;
    int lat, nr, nw, nbytes, off, r, bound;

    tbl[0]  = '{CMP,        1'b0, 2'd3, 64'd0,                  1'b0, 64'd5000,               2, 1, 0, 1'b0, 64'd0};
    tbl[1]  = '{CMP + 1,    1'b1, 2'd0, 64'hCAFE_00AB,          1'b0, 64'd0,                  3, 1, 1, 1'b1, 64'hAB88};
    tbl[2]  = '{CMP,        1'b0, 2'd3, 64'd0,                  1'b0, 64'hAB88,               2, 1, 0, 1'b0, 64'd0};
    tbl[3]  = '{CMP,        1'b1, 2'd3, 64'h1122_3344_5566_7788, 1'b0, 64'd0,                 2, 0, 1, 1'b1, 64'h1122_3344_5566_7788};
    tbl[4]  = '{CMP + 2,    1'b0, 2'd1, 64'd0,                  1'b0, 64'h5566,               2, 1, 0, 1'b0, 64'd0};
    tbl[5]  = '{64'h0200_4004, 1'b0, 2'd3, 64'd0,               1'b1, 64'd0,                  1, 0, 0, 1'b0, 64'd0};
    tbl[6]  = '{64'h1000_0000, 1'b0, 2'd3, 64'd0,               1'b1, 64'd0,                  1, 0, 0, 1'b0, 64'd0};
    tbl[7]  = '{CMP + 4,    1'b0, 2'd2, 64'd0,                  1'b0, 64'h1122_3344,          2, 1, 0, 1'b0, 64'd0};
    tbl[8]  = '{CMP + 7,    1'b0, 2'd0, 64'd0,                  1'b0, 64'h11,                 2, 1, 0, 1'b0, 64'd0};
    tbl[9]  = '{CMP + 4,    1'b1, 2'd2, 64'hFFFF_0000_DEAD_BEEF, 1'b0, 64'd0,                 3, 1, 1, 1'b1, 64'hDEAD_BEEF_5566_7788};
    tbl[10] = '{CMP + 3,    1'b1, 2'd1, 64'hFFFF,               1'b1, 64'd0,                  1, 0, 0, 1'b0, 64'd0};
    tbl[11] = '{CMP + 6,    1'b0, 2'd1, 64'd0,                  1'b0, 64'hDEAD,               2, 1, 0, 1'b0, 64'd0};
    tbl[12] = '{MT,         1'b1, 2'd3, 64'h77,                 1'b0, 64'd0,                  2, 0, 1, 1'b1, 64'h77};
    tbl[13] = '{MT + 2,     1'b1, 2'd1, 64'h1234,               1'b0, 64'd0,                  3, 1, 1, 1'b0, 64'd0};
    tbl[14] = '{CMP,        1'b0, 2'd3, 64'd0,                  1'b0, 64'hDEAD_BEEF_5566_7788, 2, 1, 0, 1'b0, 64'd0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_ren", {63'd0, clint_ren}, 64'd0);
    chk("rst_wen", {63'd0, clint_wen}, 64'd0);
    chk("rst_addr", clint_addr, 64'd0);
    chk("rst_wdata", clint_wdata, 64'd0);
    chk("rst_irq", {63'd0, timer_irq}, 64'd0);

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      do_req(tbl[i].addr, tbl[i].w, tbl[i].s, tbl[i].d, 0, rd, er, lat, nr, nw, wd, ok);
      chk($sformatf("tbl%0d_err", i), {63'd0, er}, {63'd0, tbl[i].err});
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("tbl%0d_nren", i), 64'(nr), 64'(tbl[i].nren));
      chk($sformatf("tbl%0d_nwen", i), 64'(nw), 64'(tbl[i].nwen));
      chk($sformatf("tbl%0d_addr", i), {63'd0, ok}, 64'd1);
      if (tbl[i].chkwd) chk($sformatf("tbl%0d_wdata", i), wd, tbl[i].wd);
    end
    sh = 64'hDEAD_BEEF_5566_7788;

    // Response back-pressure: 5 stalled cycles, accepted on the sixth
    do_req(CMP, 1'b0, 2'd3, 64'd0, 4, rd, er, lat, nr, nw, wd, ok);
    chk("stall_final_rdata", rd, sh);
    chk("stall_strobes", 64'(nr), 64'd1);
    @(negedge clk);
    chk("stall_post_valid", {63'd0, resp_valid}, 64'd0);
    chk("stall_post_ready", {63'd0, req_ready}, 64'd1);

    // Reset in the middle of a read-modify-write
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = CMP; req_wen = 1'b1; req_size = 2'd0; req_wdata = 64'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk("midrst_no_wen", {63'd0, clint_wen}, 64'd0);
      chk("midrst_no_resp", {63'd0, resp_valid}, 64'd0);
      @(negedge clk);
    end
    do_req(CMP, 1'b0, 2'd3, 64'd0, 0, rd, er, lat, nr, nw, wd, ok);
    chk("midrst_cmp_unchanged", rd, sh);

    // Randomized traffic against a byte-level shadow of mtimecmp
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      off = $urandom_range(0, 7);
      s = 2'($urandom_range(0, 3));
      d = {$urandom, $urandom};
      bad = (r >= 8);
      to_cmp = (r < 7);
      w = (r == 7) ? 1'b1 : 1'($urandom_range(0, 1));
      a = (r < 7) ? CMP : (r == 7) ? MT : (r == 8) ? 64'h0200_4008 : 64'h0200_BFF0;
      a = a + 64'(off);
      nbytes = 1 << s;
      mis = (off % nbytes) != 0;
      err_e = bad || mis;
      exp_rd = 64'd0;
      if (!err_e && !w)
        for (int b = 0; b < nbytes; b++) exp_rd[8*b +: 8] = sh[8*(off+b) +: 8];
      if (!err_e && w && to_cmp)
        for (int b = 0; b < nbytes; b++) sh[8*(off+b) +: 8] = d[8*b +: 8];
      do_req(a, w, s, d, 0, rd, er, lat, nr, nw, wd, ok);
      chk($sformatf("rnd%0d_err", n), {63'd0, er}, {63'd0, err_e});
      chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
      chk($sformatf("rnd%0d_lat", n), 64'(lat),
          err_e ? 64'd1 : (!w || s == 2'd3) ? 64'd2 : 64'd3);
      chk($sformatf("rnd%0d_nren", n), 64'(nr), (err_e || (w && s == 2'd3)) ? 64'd0 : 64'd1);
      chk($sformatf("rnd%0d_nwen", n), 64'(nw), (!err_e && w) ? 64'd1 : 64'd0);
      chk($sformatf("rnd%0d_addr", n), {63'd0, ok}, 64'd1);
      if (!err_e && w && to_cmp) chk($sformatf("rnd%0d_wdata", n), wd, sh);
    end

    // Timer interrupt follows mtime > mtimecmp with one cycle of delay
    bound = 0;
    while (mtime <= 64'd100 && bound < 500) begin
      @(negedge clk);
      bound++;
    end
    chk("mtime_above_100", {63'd0, mtime > 64'd100}, 64'd1);
    do_req(CMP, 1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, er, lat, nr, nw, wd, ok);
    @(negedge clk);
    chk("irq_low_before", {63'd0, timer_irq}, 64'd0);
    irq_chk = 1'b1;
    do_req(CMP, 1'b1, 2'd3, 64'd100, 0, rd, er, lat, nr, nw, wd, ok);
    @(negedge clk);
    chk("irq_high_after_cmp100", {63'd0, timer_irq}, 64'd1);
    do_req(CMP, 1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, er, lat, nr, nw, wd, ok);
    @(negedge clk);
    chk("irq_low_after_cmp_max", {63'd0, timer_irq}, 64'd0);
    irq_chk = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
